// File: rtl/enc_sched.sv
`default_nettype none
// ============================================================================
// Module   : enc_sched
// Brief    : Round-robin scheduler sharing one encoder between two requesters.
//            Optional macro ENC_SCHED_ERR_EN: mod 11 bypasses the encoder and
//            raises out_err with out_data 0.
// Revision : 1.0
// ============================================================================
module enc_sched #(
  parameter int MAX_CODEWORD_WIDTH = 32,
  parameter int MAX_INFO_WIDTH     = 26,
  parameter int ENC_LATENCY        = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req0_valid,
  input  logic                          req1_valid,
  output logic                          req0_ready,
  output logic                          req1_ready,
  input  logic [MAX_INFO_WIDTH-1:0]     req0_data,
  input  logic [MAX_INFO_WIDTH-1:0]     req1_data,
  input  logic [1:0]                    req0_mod,
  input  logic [1:0]                    req1_mod,
  output logic [MAX_INFO_WIDTH-1:0]     enc_data_in,
  output logic [1:0]                    enc_mod,
  input  logic [MAX_CODEWORD_WIDTH-1:0] enc_data_out,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [MAX_CODEWORD_WIDTH-1:0] out_data,
  output logic                          out_id
`ifdef ENC_SCHED_ERR_EN
 ,output logic                          out_err
`endif
);

  localparam int                 c_CNT_W       = 3;
  localparam logic [c_CNT_W-1:0] c_CNT_LOAD    = c_CNT_W'(ENC_LATENCY);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE     = c_CNT_W'(1);
  localparam logic [1:0]         c_MOD_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ENC  = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  state_t                          r_state;
  state_t                          w_state_nxt;
  logic                            r_prio;
  logic [MAX_INFO_WIDTH-1:0]       r_data;
  logic [1:0]                      r_mod;
  logic                            r_id;
  logic [c_CNT_W-1:0]              r_cnt;
  logic [MAX_CODEWORD_WIDTH-1:0]   r_out_data;

  logic                            w_any;
  logic                            w_grant;
  logic                            w_gnt_id;
  logic [1:0]                      w_gnt_mod;
  logic [MAX_INFO_WIDTH-1:0]       w_gnt_data;
  logic                            w_bypass;
  logic                            w_cnt_done;

  // r_prio names the requester that wins a tie.
  assign w_any      = req0_valid | req1_valid;
  assign w_gnt_id   = (req0_valid & req1_valid) ? r_prio : req1_valid;
  assign w_gnt_mod  = w_gnt_id ? req1_mod  : req0_mod;
  assign w_gnt_data = w_gnt_id ? req1_data : req0_data;
  assign w_grant    = (r_state == ST_IDLE) & w_any & ~rst;
  // The final decrement coincides with the out_data capture edge.
  assign w_cnt_done = (r_cnt <= c_CNT_ONE);

`ifdef ENC_SCHED_ERR_EN
  logic r_err;
  assign w_bypass = (w_gnt_mod == c_MOD_ILLEGAL);
  assign out_err  = r_err;
`else
  assign w_bypass = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        req0_ready = w_grant & ~w_gnt_id;
        req1_ready = w_grant &  w_gnt_id;
        if (w_grant) begin
          w_state_nxt = w_bypass ? ST_OUT : ST_ENC;
        end
      end
      ST_ENC: begin
        if (w_cnt_done) begin
          w_state_nxt = ST_OUT;
        end
      end
      ST_OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_prio     <= 1'b0;
      r_data     <= '0;
      r_mod      <= '0;
      r_id       <= 1'b0;
      r_cnt      <= '0;
      r_out_data <= '0;
`ifdef ENC_SCHED_ERR_EN
      r_err      <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        r_data <= w_gnt_data;
        r_mod  <= w_gnt_mod;
        r_id   <= w_gnt_id;
        r_prio <= ~w_gnt_id;
        r_cnt  <= c_CNT_LOAD;
        if (w_bypass) begin
          r_out_data <= '0;
        end
`ifdef ENC_SCHED_ERR_EN
        r_err  <= w_bypass;
`endif
      end else if (r_state == ST_ENC) begin
        r_cnt <= r_cnt - c_CNT_ONE;
        if (w_cnt_done) begin
          r_out_data <= enc_data_out;
        end
      end
    end
  end

  assign enc_data_in = r_data;
  assign enc_mod     = r_mod;
  assign out_data    = r_out_data;
  assign out_id      = r_id;

endmodule
`default_nettype wire

// File: tb/tb_enc_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_enc_sched
// Brief    : Self-checking bench for enc_sched (vector table + scoreboard).
// Revision : 1.0
// ============================================================================
module tb_enc_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [25:0] req0_data, req1_data;
  logic [1:0]  req0_mod, req1_mod;
  logic [25:0] enc_data_in;
  logic [1:0]  enc_mod;
  logic [31:0] enc_data_out;
  logic        out_valid, out_ready, out_id;
  logic [31:0] out_data;

  // Second instance at ENC_LATENCY=3; its req1 side is tied off.
  logic        v3_valid, v3_ready, z3_valid, z3_ready;
  logic [25:0] v3_data, z3_data, enc_data_in3;
  logic [1:0]  v3_mod, z3_mod, enc_mod3;
  logic [31:0] enc_data_out3, out_data3, s1, s2;
  logic        out_valid3, out_ready3, out_id3;
`ifdef ENC_SCHED_ERR_EN
  logic        out_err, out_err3;
`endif

  always #5 clk = ~clk;

  enc_sched dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_data(req0_data), .req1_data(req1_data),
    .req0_mod(req0_mod), .req1_mod(req1_mod),
    .enc_data_in(enc_data_in), .enc_mod(enc_mod), .enc_data_out(enc_data_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_id(out_id)
`ifdef ENC_SCHED_ERR_EN
   ,.out_err(out_err)
`endif
  );

  enc_sched #(.ENC_LATENCY(3)) dut3 (
    .clk(clk), .rst(rst),
    .req0_valid(v3_valid), .req1_valid(z3_valid),
    .req0_ready(v3_ready), .req1_ready(z3_ready),
    .req0_data(v3_data), .req1_data(z3_data),
    .req0_mod(v3_mod), .req1_mod(z3_mod),
    .enc_data_in(enc_data_in3), .enc_mod(enc_mod3), .enc_data_out(enc_data_out3),
    .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3), .out_id(out_id3)
`ifdef ENC_SCHED_ERR_EN
   ,.out_err(out_err3)
`endif
  );

  // Stub encoders: the DUT's out_data register is the last pipeline stage.
  assign enc_data_out = {enc_mod, 4'b0, enc_data_in};
  always @(posedge clk) begin
    s1 <= {enc_mod3, 4'b0, enc_data_in3};
    s2 <= s1;
  end
  assign enc_data_out3 = s2;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int hs_count = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_grant(input string name, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req0_ready || req1_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL %s actual=no_grant required=grant", name);
    end
  endtask

  // Scoreboard: expected codeword pushed at grant, popped at handshake.
  typedef struct packed {
    logic [31:0] data;
    logic        id;
    logic        err;
  } sb_t;
  sb_t  sb[$];
  logic m_prio;

  always @(negedge clk) begin : monitor
    logic        exp_id, bad;
    logic [1:0]  gmod;
    logic [25:0] gdat;
    sb_t         e, got;
    if (rst) begin
      sb.delete();
      m_prio = 1'b0;
    end else begin
      if (req0_ready || req1_ready) begin
        bad = (req0_ready && req1_ready) || out_valid ||
              (req0_ready && !req0_valid) || (req1_ready && !req1_valid);
        check("ready_legal", 64'(bad), 64'(0));
        exp_id = (req0_valid && req1_valid) ? m_prio : req1_valid;
        check("rr_model", 64'(req1_ready), 64'(exp_id));
        gmod = exp_id ? req1_mod : req0_mod;
        gdat = exp_id ? req1_data : req0_data;
        e.data = {gmod, 4'b0, gdat};
        e.id   = exp_id;
        e.err  = 1'b0;
`ifdef ENC_SCHED_ERR_EN
        if (gmod == 2'b11) begin
          e.data = 32'h0;
          e.err  = 1'b1;
        end
`endif
        sb.push_back(e);
        m_prio = ~exp_id;
      end
      if (out_valid && out_ready) begin
        hs_count++;
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_underflow actual=extra_output required=none");
        end else begin
          got = sb.pop_front();
          check("sb_data", 64'(out_data), 64'(got.data));
          check("sb_id", 64'(out_id), 64'(got.id));
`ifdef ENC_SCHED_ERR_EN
          check("sb_err", 64'(out_err), 64'(got.err));
`endif
        end
      end
    end
  end

  typedef struct {
    logic        sel;
    logic [1:0]  mod;
    logic [25:0] data;
    logic [31:0] exp_data;
    logic        exp_err;
    int          lat;
  } vec_t;
  vec_t vec [5];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ok, seen;
    int   k, prev;

    vec[0] = '{1'b0, 2'b00, 26'h0000003, 32'h0000_0003, 1'b0, 2};
    vec[1] = '{1'b1, 2'b01, 26'h00007FF, 32'h4000_07FF, 1'b0, 2};
    vec[2] = '{1'b0, 2'b10, 26'h3FFFFFF, 32'h83FF_FFFF, 1'b0, 2};
`ifdef ENC_SCHED_ERR_EN
    vec[3] = '{1'b1, 2'b11, 26'h0000155, 32'h0000_0000, 1'b1, 1};
`else
    vec[3] = '{1'b1, 2'b11, 26'h0000155, 32'hC000_0155, 1'b0, 2};
`endif
    vec[4] = '{1'b1, 2'b00, 26'h2AAAAAA, 32'h02AA_AAAA, 1'b0, 2};

    rst = 1'b1; out_ready = 1'b1;
    req0_valid = 1'b1; req0_data = 26'h3FFFFFF; req0_mod = 2'b10;
    req1_valid = 1'b0; req1_data = '0; req1_mod = '0;
    v3_valid = 1'b0; v3_data = '0; v3_mod = '0;
    z3_valid = 1'b0; z3_data = '0; z3_mod = '0; out_ready3 = 1'b1;

    // Reset state, with a request pending to show ready stays low.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready0", 64'(req0_ready), 64'(0));
    check("rst_ready1", 64'(req1_ready), 64'(0));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_data", 64'(out_data), 64'(0));
    check("rst_out_id", 64'(out_id), 64'(0));
    check("rst_enc_data", 64'(enc_data_in), 64'(0));
    check("rst_enc_mod", 64'(enc_mod), 64'(0));
`ifdef ENC_SCHED_ERR_EN
    check("rst_out_err", 64'(out_err), 64'(0));
`endif
    @(posedge clk); #1;
    rst = 1'b0; req0_valid = 1'b0;

    // Single-requester vectors.
    for (int i = 0; i < 5; i++) begin
      if (vec[i].sel) begin
        req1_valid = 1'b1; req1_data = vec[i].data; req1_mod = vec[i].mod;
      end else begin
        req0_valid = 1'b1; req0_data = vec[i].data; req0_mod = vec[i].mod;
      end
      wait_grant("vec_grant_timeout", ok);
      if (ok) begin
        check("vec_grant_id", 64'(req1_ready), 64'(vec[i].sel));
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        k = 0; seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
          @(negedge clk);
          k++;
          if (out_valid) seen = 1'b1;
        end
        check("vec_latency", 64'(k), 64'(vec[i].lat));
        check("vec_data", 64'(out_data), 64'(vec[i].exp_data));
        check("vec_id", 64'(out_id), 64'(vec[i].sel));
`ifdef ENC_SCHED_ERR_EN
        check("vec_err", 64'(out_err), 64'(vec[i].exp_err));
`endif
      end
      @(posedge clk); #1;
      req0_valid = 1'b0; req1_valid = 1'b0;
    end

    // Continuous contention: alternating grants, next grant one cycle after handshake.
    req0_valid = 1'b1; req0_data = 26'h1; req0_mod = 2'b00;
    req1_valid = 1'b1; req1_data = 26'h2; req1_mod = 2'b00;
    prev = 0;
    for (int g = 0; g < 4; g++) begin
      wait_grant("rr_grant_timeout", ok);
      if (ok) begin
        check("rr_grant", 64'(req1_ready), 64'(g % 2));
        if (g > 0) check("rr_spacing", 64'(cyc - prev), 64'(3));
        prev = cyc;
      end
    end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (5) @(posedge clk); #1;

    // Back-pressure with both requesters waiting.
    out_ready = 1'b0;
    req0_valid = 1'b1; req0_data = 26'h5; req0_mod = 2'b00;
    wait_grant("bp_grant_timeout", ok);
    @(posedge clk); #1;
    req0_data = 26'h6; req1_valid = 1'b1; req1_data = 26'h7;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("bp_out_valid_seen", 64'(seen), 64'(1));
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("bp_hold_valid", 64'(out_valid), 64'(1));
      check("bp_hold_data", 64'(out_data), 64'(32'h5));
      check("bp_readys_low", 64'({req0_ready, req1_ready}), 64'(0));
    end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    k = hs_count;
    out_ready = 1'b1;
    repeat (6) @(negedge clk);
    check("bp_one_handshake", 64'(hs_count - k), 64'(1));
    @(posedge clk); #1;

    // Reset during ENC drops the word and restores priority to req0.
    req0_valid = 1'b1; req0_data = 26'h9; req0_mod = 2'b01;
    wait_grant("rst_grant_timeout", ok);
    @(posedge clk); #1;
    req0_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("rst_no_out_valid", 64'(out_valid), 64'(0));
    end
    check("rst_mid_enc_data", 64'(enc_data_in), 64'(0));
    check("rst_mid_out_data", 64'(out_data), 64'(0));
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_data = 26'hA; req0_mod = 2'b00;
    req1_valid = 1'b1; req1_data = 26'hB; req1_mod = 2'b00;
    wait_grant("rst_rr_timeout", ok);
    if (ok) check("rst_rr_req0", 64'(req0_ready), 64'(1));
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (5) @(posedge clk); #1;

    // ENC_LATENCY=3 instance: 4-cycle delay, encoder input held through ENC.
    v3_valid = 1'b1; v3_data = 26'h1234; v3_mod = 2'b10;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (v3_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("l3_grant", 64'(ok), 64'(1));
    @(posedge clk); #1;
    v3_valid = 1'b0;
    k = 0; seen = 1'b0;
    for (int c = 0; c < 12 && !seen; c++) begin
      @(negedge clk);
      k++;
      if (out_valid3) begin
        seen = 1'b1;
      end else begin
        check("l3_enc_data", 64'(enc_data_in3), 64'(26'h1234));
        check("l3_enc_mod", 64'(enc_mod3), 64'(2'b10));
      end
    end
    check("l3_latency", 64'(k), 64'(4));
    check("l3_data", 64'(out_data3), 64'(32'h8000_1234));
    check("l3_id", 64'(out_id3), 64'(0));
    repeat (3) @(posedge clk);

    check("sb_drained", 64'(sb.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/enc_sched.md
ENC_SCHED -- requirements
Module: enc_sched

Interface
REQ-001 SHALL have parameter MAX_CODEWORD_WIDTH, default 32, meaning codeword width.
REQ-002 SHALL have parameter MAX_INFO_WIDTH, default 26, meaning info width.
REQ-003 SHALL have parameter ENC_LATENCY, default 1, meaning cycles from encoder input to registered encoder output (range 1..7).
REQ-004 SHALL have ports clk  in  1  clock, and rst  in  1  reset; one clock; reset is synchronous and active-high.
REQ-005 SHALL have ports req0_valid/req1_valid  in  1  request present.
REQ-006 SHALL have ports req0_ready/req1_ready  out  1  request accepted this cycle.
REQ-007 SHALL have ports req0_data/req1_data  in  MAX_INFO_WIDTH  info word.
REQ-008 SHALL have ports req0_mod/req1_mod  in  2  code select (00 = 8/4, 01 = 16/11, 10 = 32/26, 11 = illegal).
REQ-009 SHALL have ports enc_data_in  out  MAX_INFO_WIDTH, enc_mod  out  2, and enc_data_out  in  MAX_CODEWORD_WIDTH, connecting to the shared encoder.
REQ-010 SHALL have ports out_valid  out  1, out_ready  in  1, out_data  out  MAX_CODEWORD_WIDTH, and out_id  out  1 (requester index).

Function
REQ-011 SHALL implement a 3-state FSM: IDLE, ENC, OUT.
REQ-012 IDLE: when at least one req*_valid is high, SHALL grant one requester, assert its ready for exactly that cycle, latch data/mod/id, and go to ENC; otherwise SHALL stay in IDLE.
REQ-013 Arbitration SHALL be round-robin: when both are valid, grant the requester not granted last; a lone valid requester SHALL be granted immediately.
REQ-014 A ready SHALL never be asserted outside IDLE, and never to both requesters in the same cycle.
REQ-015 ENC: enc_data_in/enc_mod SHALL be driven from the latched registers and held stable; a down-counter loaded with ENC_LATENCY SHALL decrement each cycle.
REQ-016 When the counter reaches 0, SHALL capture enc_data_out into out_data and go to OUT; the total grant-to-out_valid delay SHALL be ENC_LATENCY+1 cycles.
REQ-017 OUT: out_valid SHALL be high with out_data/out_id stable until out_valid&&out_ready, then SHALL go to IDLE on the next edge.
REQ-018 Simultaneous out_ready and a new request in OUT SHALL NOT be accepted in the same cycle; acceptance occurs in the following IDLE cycle.
REQ-019 In IDLE/OUT, enc_data_in and enc_mod SHALL hold their last latched values (no toggling).
REQ-020 Back-pressure of any length on out_ready SHALL not lose or duplicate a codeword.

Reset
REQ-021 rst SHALL force, on the next edge: state IDLE, ready outputs 0, out_valid 0, out_data 0, out_id 0, enc_data_in 0, enc_mod 0, counter 0, and round-robin priority to requester 0.
REQ-022 Reset asserted mid-ENC or mid-OUT SHALL abort the transaction; the in-flight word SHALL be dropped with no out_valid.

Configuration
REQ-023 Macro ENC_SCHED_ERR_EN SHALL control illegal-mode handling.
REQ-024 With ENC_SCHED_ERR_EN defined: the block SHALL add port out_err  out  1; a granted request with mod 11 SHALL bypass ENC, go IDLE->OUT directly with out_data 0 and out_err 1; out_err SHALL be 0 for legal modes and reset to 0.
REQ-025 Without ENC_SCHED_ERR_EN: the out_err port SHALL be absent, and mod 11 SHALL be sequenced through ENC like any other mode, passing enc_data_out unchanged.

Verification (bench stub encoder: registered output {mod, 4'b0, data} after ENC_LATENCY cycles)
REQ-026 A single req0, data 26'h3, mod 00, ENC_LATENCY 1, out_ready=1 SHALL produce req0_ready for 1 cycle, then out_valid 2 cycles later with out_data 32'h0000_0003 and out_id 0.
REQ-027 req0 and req1 both valid continuously (data 1 and 2) SHALL produce grants alternating 0,1,0,1 and out_id sequence 0,1,0,1.
REQ-028 A held out_ready=0 for 10 cycles with out_valid high SHALL keep out_data stable and keep both readys low; releasing it SHALL yield exactly one handshake.
REQ-029 ENC_LATENCY=3 SHALL give a grant-to-out_valid delay of 4 cycles, with enc_data_in stable throughout ENC.
REQ-030 Asserting rst in the ENC cycle SHALL give no out_valid afterwards, and the next simultaneous request pair SHALL be granted to req0.
REQ-031 With ENC_SCHED_ERR_EN, req1 with mod 11 SHALL give out_valid on the cycle after the grant, with out_data 0, out_err 1, and out_id 1; without the macro, out_data SHALL be the stub value {2'b11, 4'b0, data}.
